// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32 datapath: a phase FSM (FETCH, DECODE, EXEC, MEM, WB, ERR) sequences handshaked
// instruction/data memory accesses around an internal register file and ALU driven by external control.
module multicycle_datapath #(
  parameter logic [31:0] INITIAL_PC  = 32'h00400000,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] iAddress,
  output logic        iReq,
  input  logic        iReady,
  input  logic [31:0] instr,
  output logic [31:0] ir,
  input  logic        ALUSrc,
  input  logic [3:0]  ALUCtrl,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        Jump,
  output logic [31:0] PC,
  output logic        Zero,
  output logic [31:0] dAddress,
  output logic [31:0] dWriteData,
  output logic        dReq,
  output logic        dWe,
  input  logic        dReady,
  input  logic [31:0] dReadData,
  output logic [31:0] WriteBackData,
  output logic [2:0]  state,
  output logic        instrDone,
  output logic        memErr
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, a_q, b_q, imm_q, aluOut_q, mdr_q;
  logic          zero_q;
  logic [CW-1:0] wait_q;
  logic [31:0]   rf_q [32];

  logic [31:0] immGen, op2, aluRes, wbData;
  logic [4:0]  rd;
  logic        isLoad, waitExpired;

  assign rd          = ir_q[11:7];
  assign isLoad      = MemRead & ~MemWrite;
  assign waitExpired = (wait_q == CW'(MEM_TIMEOUT - 1));
  assign op2         = ALUSrc ? imm_q : b_q;
  assign wbData      = Jump ? (pc_q + 32'd4) : (MemToReg ? mdr_q : aluOut_q);

  always_comb begin
    immGen = '0;
    case (ir_q[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: immGen = {{20{ir_q[31]}}, ir_q[31:20]};
      7'b0100011: immGen = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      7'b1100011: immGen = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      7'b0110111, 7'b0010111: immGen = {ir_q[31:12], 12'd0};
      7'b1101111: immGen = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: immGen = '0;
    endcase
  end

  // ALU codes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLT, 8 SRA, 9 SLTU, 12 NOR
  always_comb begin
    aluRes = '0;
    case (ALUCtrl)
      4'b0000: aluRes = a_q & op2;
      4'b0001: aluRes = a_q | op2;
      4'b0010: aluRes = a_q + op2;
      4'b0011: aluRes = a_q ^ op2;
      4'b0100: aluRes = a_q << op2[4:0];
      4'b0101: aluRes = a_q >> op2[4:0];
      4'b0110: aluRes = a_q - op2;
      4'b0111: aluRes = {31'd0, $signed(a_q) < $signed(op2)};
      4'b1000: aluRes = $unsigned($signed(a_q) >>> op2[4:0]);
      4'b1001: aluRes = {31'd0, a_q < op2};
      4'b1100: aluRes = ~(a_q | op2);
      default: aluRes = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH: begin
        if (iReady)           state_d = S_DECODE;
        else if (waitExpired) state_d = S_ERR;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (MemRead | MemWrite) ? S_MEM : S_WB;
      S_MEM: begin
        if (dReady)           state_d = S_WB;
        else if (waitExpired) state_d = S_ERR;
      end
      S_WB: begin
        state_d = S_FETCH;
        if (Jump)                pc_d = pc_q + imm_q;
        else if (Branch & zero_q) pc_d = pc_q + imm_q;
        else                     pc_d = pc_q + 32'd4;
      end
      default: state_d = S_ERR;
    endcase
  end

  // The wait counter only advances while stalled on a handshake and restarts on any phase change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= INITIAL_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluOut_q <= '0;
      mdr_q    <= '0;
      zero_q   <= 1'b0;
      wait_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_d != state_q)                          wait_q <= '0;
      else if (state_q == S_FETCH || state_q == S_MEM) wait_q <= wait_q + 1'b1;
      case (state_q)
        S_FETCH:  if (iReady) ir_q <= instr;
        S_DECODE: begin
          a_q   <= rf_q[ir_q[19:15]];
          b_q   <= rf_q[ir_q[24:20]];
          imm_q <= immGen;
        end
        S_EXEC: begin
          aluOut_q <= aluRes;
          zero_q   <= (aluRes == 32'd0);
        end
        S_MEM:    if (dReady && isLoad) mdr_q <= dReadData;
        S_WB:     if (RegWrite && rd != 5'd0) rf_q[rd] <= wbData;
        default: ;
      endcase
    end
  end

  assign iAddress      = pc_q;
  assign PC            = pc_q;
  assign ir            = ir_q;
  assign Zero          = zero_q;
  assign dAddress      = aluOut_q;
  assign dWriteData    = b_q;
  assign WriteBackData = wbData;
  assign state         = state_q;
  assign iReq          = (state_q == S_FETCH) && !rst;
  assign dReq          = (state_q == S_MEM) && !rst;
  assign dWe           = dReq & MemWrite;
  assign instrDone     = (state_q == S_WB);
  assign memErr        = (state_q == S_ERR);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: instruction-level reference model plus a per-cycle compare process,
// directed RV32 programme with literal expectations, random instructions, timeouts and mid-access reset.
module tb_multicycle_datapath;

  localparam logic [31:0] INIT_PC = 32'h00400000;
  localparam int          TMO     = 16;

  logic        clk, rst;
  logic [31:0] iAddress, instr, ir, PC, dAddress, dWriteData, dReadData, WriteBackData;
  logic        iReq, iReady, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch, Jump;
  logic        Zero, dReq, dWe, dReady, instrDone, memErr;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;

  typedef struct packed {
    logic       aluSrc;
    logic [3:0] aluCtrl;
    logic       regWrite, memToReg, memRead, memWrite, branch, jump;
  } ctrl_t;

  multicycle_datapath #(.INITIAL_PC(INIT_PC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .iAddress(iAddress), .iReq(iReq), .iReady(iReady), .instr(instr),
    .ir(ir), .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .PC(PC), .Zero(Zero),
    .dAddress(dAddress), .dWriteData(dWriteData), .dReq(dReq), .dWe(dWe), .dReady(dReady),
    .dReadData(dReadData), .WriteBackData(WriteBackData), .state(state), .instrDone(instrDone),
    .memErr(memErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  logic [31:0] mRegs [32];
  logic [31:0] mPc, mMdr, mIr;
  logic        mZero;

  bit          chkEn = 1'b0;
  logic [2:0]  eState;
  logic        eIReq, eDReq, eDWe, eDone, eErr, eZero;
  logic [31:0] ePc, eIr, eDAddr, eDWdata, eWb;
  logic [31:0] lastWb, dutWb, dutDAddr, dutDWdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("state", 32'(state), 32'(eState));
      checkOutput("iReq", 32'(iReq), 32'(eIReq));
      checkOutput("dReq", 32'(dReq), 32'(eDReq));
      checkOutput("dWe", 32'(dWe), 32'(eDWe));
      checkOutput("instrDone", 32'(instrDone), 32'(eDone));
      checkOutput("memErr", 32'(memErr), 32'(eErr));
      checkOutput("PC", PC, ePc);
      checkOutput("iAddress", iAddress, ePc);
      checkOutput("ir", ir, eIr);
      checkOutput("Zero", 32'(Zero), 32'(eZero));
      if (eDReq) begin
        checkOutput("dAddress", dAddress, eDAddr);
        checkOutput("dWriteData", dWriteData, eDWdata);
      end
      if (eDone) checkOutput("WriteBackData", WriteBackData, eWb);
    end
  end

  function automatic logic [31:0] immOf(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return {{20{i[31]}}, i[31:20]};
      7'h23: return {{20{i[31]}}, i[31:25], i[11:7]};
      7'h63: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'h37, 7'h17: return {i[31:12], 12'h000};
      7'h6F: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] aluOf(input logic [3:0] code, input logic [31:0] x, input logic [31:0] y);
    case (code)
      4'd0:  return x & y;
      4'd1:  return x | y;
      4'd2:  return x + y;
      4'd3:  return x ^ y;
      4'd4:  return x << y[4:0];
      4'd5:  return x >> y[4:0];
      4'd6:  return x - y;
      4'd7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  return $unsigned($signed(x) >>> y[4:0]);
      4'd9:  return (x < y) ? 32'd1 : 32'd0;
      4'd12: return ~(x | y);
      default: return 32'd0;
    endcase
  endfunction

  function automatic ctrl_t mk(input logic s, input logic [3:0] a, input logic rw, input logic m2r,
                               input logic mr, input logic mw, input logic br, input logic j);
    return {s, a, rw, m2r, mr, mw, br, j};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setExp(input logic [2:0] s);
    eState = s;
    eIReq  = (s == 3'd0);
    eDReq  = (s == 3'd3);
    eDWe   = 1'b0;
    eDone  = (s == 3'd4);
    eErr   = (s == 3'd7);
    ePc    = mPc;
    eIr    = mIr;
    eZero  = mZero;
  endtask

  task automatic errCycles();
    for (int k = 0; k < 4; k++) begin
      iReady = 1'($urandom_range(0, 1));
      dReady = 1'($urandom_range(0, 1));
      setExp(3'd7);
      step();
    end
  endtask

  task automatic resetDut();
    chkEn  = 1'b0;
    rst    = 1'b1;
    iReady = 1'b0;
    dReady = 1'b0;
    @(negedge clk);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_iReq", 32'(iReq), 32'd0);
    checkOutput("rst_dReq", 32'(dReq), 32'd0);
    checkOutput("rst_dWe", 32'(dWe), 32'd0);
    checkOutput("rst_PC", PC, INIT_PC);
    checkOutput("rst_ir", ir, 32'd0);
    checkOutput("rst_Zero", 32'(Zero), 32'd0);
    checkOutput("rst_instrDone", 32'(instrDone), 32'd0);
    checkOutput("rst_memErr", 32'(memErr), 32'd0);
    checkOutput("rst_dAddress", dAddress, 32'd0);
    checkOutput("rst_dWriteData", dWriteData, 32'd0);
    step();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) mRegs[r] = 32'd0;
    mPc   = INIT_PC;
    mMdr  = 32'd0;
    mIr   = 32'd0;
    mZero = 1'b0;
    chkEn = 1'b1;
  endtask

  // Runs one instruction through the DUT while the model predicts every phase; abortMem >= 0 leaves mid-MEM.
  task automatic applyStimulus(input logic [31:0] ins, input ctrl_t c, input int iWaits, input int dWaits,
                               input logic [31:0] rdata, input int abortMem);
    logic [31:0] a, b, op2, imm, res, wb, nextPc;
    logic        z, isMem, isLoad;
    logic [4:0]  rd;
    {ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite, Branch, Jump} = c;
    for (int w = 0; w <= TMO; w++) begin
      if (w == TMO) begin
        errCycles();
        return;
      end
      iReady    = (w == iWaits);
      instr     = (w == iWaits) ? ins : $urandom;
      dReady    = 1'($urandom_range(0, 1));
      dReadData = $urandom;
      setExp(3'd0);
      step();
      if (w == iWaits) break;
    end
    mIr    = ins;
    instr  = $urandom;
    rd     = ins[11:7];
    imm    = immOf(ins);
    a      = mRegs[ins[19:15]];
    b      = mRegs[ins[24:20]];
    op2    = c.aluSrc ? imm : b;
    res    = aluOf(c.aluCtrl, a, op2);
    z      = (res == 32'd0);
    isMem  = c.memRead | c.memWrite;
    isLoad = c.memRead & ~c.memWrite;
    for (int p = 1; p <= 2; p++) begin
      iReady = 1'($urandom_range(0, 1));
      dReady = 1'($urandom_range(0, 1));
      setExp(3'(p));
      step();
    end
    mZero = z;
    if (isMem) begin
      for (int w = 0; w <= TMO; w++) begin
        if (w == TMO) begin
          errCycles();
          return;
        end
        if (w == abortMem) return;
        dReady    = (w == dWaits);
        dReadData = (w == dWaits) ? rdata : $urandom;
        iReady    = 1'($urandom_range(0, 1));
        setExp(3'd3);
        eDWe    = c.memWrite;
        eDAddr  = res;
        eDWdata = b;
        if (w == 0) begin
          dutDAddr  = dAddress;
          dutDWdata = dWriteData;
        end
        step();
        if (w == dWaits) break;
      end
      if (isLoad) mMdr = rdata;
    end
    wb     = c.jump ? mPc + 32'd4 : (c.memToReg ? mMdr : res);
    nextPc = (c.jump || (c.branch && z)) ? mPc + imm : mPc + 32'd4;
    iReady = 1'($urandom_range(0, 1));
    dReady = 1'($urandom_range(0, 1));
    setExp(3'd4);
    eWb   = wb;
    dutWb = WriteBackData;
    step();
    if (c.regWrite && rd != 5'd0) mRegs[rd] = wb;
    mPc    = nextPc;
    lastWb = wb;
  endtask

  function automatic logic [6:0] randOpcode();
    case ($urandom_range(0, 9))
      0: return 7'h13;
      1: return 7'h03;
      2: return 7'h67;
      3: return 7'h23;
      4: return 7'h63;
      5: return 7'h37;
      6: return 7'h17;
      7: return 7'h6F;
      8: return 7'h33;
      default: return 7'h0B;
    endcase
  endfunction

  function automatic logic [3:0] randAluCode();
    case ($urandom_range(0, 10))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd3;
      4: return 4'd4;
      5: return 4'd5;
      6: return 4'd6;
      7: return 4'd7;
      8: return 4'd8;
      9: return 4'd9;
      default: return 4'd12;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
    failCount++;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ctrl_t       addiC, swC, lwC, beqC, jalC, addC, rc;
    logic [31:0] r, ins;
    logic [6:0]  op;
    rst = 1'b1; iReady = 1'b0; dReady = 1'b0; instr = '0; dReadData = '0;
    {ALUSrc, ALUCtrl, RegWrite, MemToReg, MemRead, MemWrite, Branch, Jump} = '0;
    addiC = mk(1, 4'd2, 1, 0, 0, 0, 0, 0);
    swC   = mk(1, 4'd2, 0, 0, 0, 1, 0, 0);
    lwC   = mk(1, 4'd2, 1, 1, 1, 0, 0, 0);
    beqC  = mk(0, 4'd6, 0, 0, 0, 0, 1, 0);
    jalC  = mk(1, 4'd2, 1, 0, 0, 0, 0, 1);
    addC  = mk(0, 4'd2, 1, 0, 0, 0, 0, 0);
    step();
    resetDut();

    $display("[TB] directed programme");
    applyStimulus(32'h00500093, addiC, 0, 0, 0, -1);
    checkOutput("addi_model_wb", lastWb, 32'd5);
    checkOutput("addi_wb", dutWb, 32'd5);
    checkOutput("addi_pc", PC, 32'h00400004);
    applyStimulus(32'h00100013, addiC, 0, 0, 0, -1);
    applyStimulus(32'h00102623, swC, 1, 3, 0, -1);
    checkOutput("sw_dAddress", dutDAddr, 32'd12);
    checkOutput("sw_dWriteData", dutDWdata, 32'd5);
    applyStimulus(32'h00C02103, lwC, 0, 2, 32'hDEADBEEF, -1);
    checkOutput("lw_wb", dutWb, 32'hDEADBEEF);
    checkOutput("lw_pc", PC, 32'h00400010);
    applyStimulus(32'hFE108CE3, beqC, 0, 0, 0, -1);
    checkOutput("beq_zero", 32'(Zero), 32'd1);
    checkOutput("beq_pc", PC, 32'h00400008);
    applyStimulus(32'hFE208CE3, beqC, 2, 0, 0, -1);
    checkOutput("bne_zero", 32'(Zero), 32'd0);
    checkOutput("bne_pc", PC, 32'h0040000C);
    for (int k = 0; k < 5; k++) applyStimulus(32'h00000013, addiC, 0, 0, 0, -1);
    checkOutput("nop_pc", PC, 32'h00400020);
    applyStimulus(32'h010000EF, jalC, 0, 0, 0, -1);
    checkOutput("jal_wb", dutWb, 32'h00400024);
    checkOutput("jal_pc", PC, 32'h00400030);
    applyStimulus(32'h123451B7, addiC, 0, 0, 0, -1);
    checkOutput("lui_wb", dutWb, 32'h12345000);
    applyStimulus(32'h002002B3, addC, 0, 0, 0, -1);
    checkOutput("x0_read_zero", dutWb, 32'hDEADBEEF);

    $display("[TB] random instructions");
    for (int n = 0; n < 150; n++) begin
      r          = $urandom;
      op         = randOpcode();
      ins        = {r[31:7], op};
      rc.aluSrc   = 1'($urandom_range(0, 1));
      rc.aluCtrl  = randAluCode();
      rc.regWrite = 1'($urandom_range(0, 1));
      rc.memToReg = 1'($urandom_range(0, 1));
      rc.memRead  = ($urandom_range(0, 3) == 0);
      rc.memWrite = ($urandom_range(0, 3) == 0);
      rc.branch   = (op == 7'h63) && ($urandom_range(0, 1) == 1);
      rc.jump     = (op == 7'h6F) && ($urandom_range(0, 1) == 1);
      applyStimulus(ins, rc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, -1);
    end

    $display("[TB] reset during data access");
    applyStimulus(32'h00102623, swC, 0, 10, 0, 2);
    chkEn = 1'b0;
    checkOutput("pre_rst_dReq", 32'(dReq), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_dReq", 32'(dReq), 32'd0);
    checkOutput("async_rst_state", 32'(state), 32'd0);
    checkOutput("async_rst_pc", PC, INIT_PC);
    resetDut();

    $display("[TB] fetch timeout");
    applyStimulus(32'h00500093, addiC, 1000, 0, 0, -1);
    checkOutput("ifetch_tmo_state", 32'(state), 32'd7);
    checkOutput("ifetch_tmo_memErr", 32'(memErr), 32'd1);
    checkOutput("ifetch_tmo_pc", PC, INIT_PC);
    resetDut();

    $display("[TB] data timeout");
    applyStimulus(32'h00500093, addiC, 0, 0, 0, -1);
    applyStimulus(32'h00C02103, lwC, 0, 1000, 32'h1, -1);
    checkOutput("dmem_tmo_state", 32'(state), 32'd7);
    checkOutput("dmem_tmo_dReq", 32'(dReq), 32'd0);
    checkOutput("dmem_tmo_pc", PC, 32'h00400004);
    chkEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
